// File: rtl/systolic_host_ctrl_pkg.sv
// Shared types and constants for the host side of the 4x4 systolic MAC core.
// The matrix and result widths are derived from the core geometry.
package systolic_pkg;

    localparam int MAT_DIM = 4;
    localparam int ELEM_W  = 8;
    localparam int ACC_W   = 32;
    localparam int BEAT_W  = 64;

    localparam int MAT_W   = MAT_DIM * MAT_DIM * ELEM_W;
    localparam int RES_W   = MAT_DIM * MAT_DIM * ACC_W;

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        RECV,
        DONE,
        ERR
    } host_state_t;

endpackage

// File: rtl/systolic_host_ctrl_beat_serializer.sv
// Holds the captured A/B matrices and presents one registered 64-bit input beat:
// {A row k, B column k}, with element 0 of each group in the most significant byte.
module beat_serializer
    import systolic_pkg::*;
#(
    parameter int IW = 3
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_load,
    input  logic              i_advance,
    input  logic [IW-1:0]     i_idx,
    input  logic [MAT_W-1:0]  i_a_mat,
    input  logic [MAT_W-1:0]  i_b_mat,
    output logic [BEAT_W-1:0] o_beat
);

    logic [MAT_W-1:0]  r_a;
    logic [MAT_W-1:0]  r_b;
    logic [BEAT_W-1:0] r_beat;
    logic [BEAT_W-1:0] w_next_beat;

    function automatic logic [BEAT_W-1:0] pack_beat(input logic [MAT_W-1:0] a,
                                                     input logic [MAT_W-1:0] b,
                                                     input int               k);
        logic [BEAT_W-1:0] v;
        v = '0;
        for (int e = 0; e < MAT_DIM; e++) begin
            v[BEAT_W-1-ELEM_W*e -: ELEM_W]   = a[MAT_W-1-ELEM_W*(MAT_DIM*k+e) -: ELEM_W];
            v[BEAT_W/2-1-ELEM_W*e -: ELEM_W] = b[MAT_W-1-ELEM_W*(MAT_DIM*e+k) -: ELEM_W];
        end
        return v;
    endfunction

    always_comb begin
        w_next_beat = '0;
        for (int k = 0; k < MAT_DIM; k++) begin
            if (i_idx == IW'(k)) begin
                w_next_beat = pack_beat(r_a, r_b, k);
            end
        end
    end

    // Beat 0 is built straight from the inputs so it is ready the cycle SEND begins.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_beat <= '0;
        end else if (i_load) begin
            r_a    <= i_a_mat;
            r_b    <= i_b_mat;
            r_beat <= pack_beat(i_a_mat, i_b_mat, 0);
        end else if (i_advance) begin
            r_beat <= w_next_beat;
        end
    end

    assign o_beat = r_beat;

endmodule

// File: rtl/systolic_host_ctrl.sv
// Host controller: streams A/B to the systolic core as input beats, collects the
// result beats into a 512-bit word, and aborts on timeout or an early core answer.
module systolic_host_ctrl
    import systolic_pkg::*;
#(
    parameter int N_IN_BEATS  = 4,
    parameter int N_OUT_BEATS = 8,
    parameter int TIMEOUT     = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [MAT_W-1:0]  a_mat,
    input  logic [MAT_W-1:0]  b_mat,
    output logic [BEAT_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              tx_sof,
    input  logic [BEAT_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [RES_W-1:0]  result
);

    localparam int KW = $clog2(N_IN_BEATS + 1);
    localparam int JW = $clog2(N_OUT_BEATS + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    host_state_t      r_state;
    host_state_t      w_next;
    logic [KW-1:0]    r_kcnt;
    logic [JW-1:0]    r_jcnt;
    logic [TW-1:0]    r_idle;
    logic [RES_W-1:0] r_result;

    logic [KW-1:0]    w_knext;
    logic             w_load;
    logic             w_adv;
    logic             w_tx_hs;
    logic             w_rx_hs;
    logic             w_timeout;
    logic             w_k_last;
    logic             w_j_last;

    assign w_knext   = r_kcnt + KW'(1);
    assign w_tx_hs   = (r_state == SEND) && tx_ready;
    assign w_rx_hs   = (r_state == RECV) && rx_valid;
    assign w_timeout = (r_idle == TW'(TIMEOUT - 1));
    assign w_k_last  = (r_kcnt == KW'(N_IN_BEATS - 1));
    assign w_j_last  = (r_jcnt == JW'(N_OUT_BEATS - 1));
    assign w_load    = (r_state == IDLE) && start;
    assign w_adv     = w_tx_hs && !rx_valid && !w_k_last;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (start) w_next = SEND;
            SEND: begin
                // A core answering before all input is delivered is a protocol fault.
                if (rx_valid)          w_next = ERR;
                else if (tx_ready)     w_next = w_k_last ? RECV : SEND;
                else if (w_timeout)    w_next = ERR;
            end
            RECV: begin
                if (rx_valid)          w_next = w_j_last ? DONE : RECV;
                else if (w_timeout)    w_next = ERR;
            end
            DONE:    w_next = IDLE;
            ERR:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_kcnt <= '0;
            r_jcnt <= '0;
            r_idle <= '0;
        end else begin
            if (w_load) begin
                r_kcnt <= '0;
                r_jcnt <= '0;
            end
            if (w_adv)   r_kcnt <= w_knext;
            if (w_rx_hs) r_jcnt <= r_jcnt + JW'(1);

            // Idle counter stops at TIMEOUT at most, since reaching TIMEOUT-1 leaves SEND/RECV.
            if (w_load || w_tx_hs || w_rx_hs)
                r_idle <= '0;
            else if (r_state == SEND || r_state == RECV)
                r_idle <= r_idle + TW'(1);
        end
    end

    // Cleared on the way into ERR so the aborted job never shows a partial result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_result <= '0;
        end else if (w_next == ERR) begin
            r_result <= '0;
        end else if (w_rx_hs) begin
            for (int s = 0; s < N_OUT_BEATS; s++) begin
                if (r_jcnt == JW'(s)) r_result[RES_W-1-BEAT_W*s -: BEAT_W] <= rx_data;
            end
        end
    end

    beat_serializer #(
        .IW (KW)
    ) u_ser (
        .i_clk     (clk),
        .i_rst     (reset),
        .i_load    (w_load),
        .i_advance (w_adv),
        .i_idx     (w_knext),
        .i_a_mat   (a_mat),
        .i_b_mat   (b_mat),
        .o_beat    (tx_data)
    );

    assign tx_valid = (r_state == SEND);
    assign tx_sof   = (r_state == SEND) && (r_kcnt == '0);
    assign rx_ready = (r_state == RECV);
    assign busy     = (r_state == SEND) || (r_state == RECV);
    assign done     = (r_state == DONE);
    assign error    = (r_state == ERR);
    assign result   = r_result;

endmodule

// File: tb/tb_systolic_host_ctrl.sv
// Directed bench for systolic_host_ctrl: identity job, backpressure, rx gaps,
// timeout, ignored start, early-rx fault and mid-job reset.
module tb_systolic_host_ctrl;

    logic         clk;
    logic         reset;
    logic         start;
    logic [127:0] a_mat;
    logic [127:0] b_mat;
    logic [63:0]  tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic         tx_sof;
    logic [63:0]  rx_data;
    logic         rx_valid;
    logic         rx_ready;
    logic         busy;
    logic         done;
    logic         error;
    logic [511:0] result;

    int errs;
    int checks;

    logic [63:0]  exp_b [4];
    logic [63:0]  id_b  [4];
    logic [63:0]  alt_b [4];
    logic [511:0] exp_res;
    logic [127:0] mat_i;
    logic [127:0] mat_seq;

    systolic_host_ctrl #(
        .N_IN_BEATS  (4),
        .N_OUT_BEATS (8),
        .TIMEOUT     (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .a_mat    (a_mat),
        .b_mat    (b_mat),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx_sof   (tx_sof),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .result   (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_job(input logic [127:0] a, input logic [127:0] b);
        a_mat = a;
        b_mat = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_job(input int stall_k, input int stall_n);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("tx_valid_b%0d", k), tx_valid, 1'b1);
            chk($sformatf("tx_sof_b%0d", k), tx_sof, (k == 0));
            chk($sformatf("tx_data_b%0d", k), tx_data, exp_b[k]);
            if (k == stall_k) begin
                for (int s = 0; s < stall_n; s++) begin
                    @(negedge clk);
                    chk("stall_data", tx_data, exp_b[k]);
                    chk("stall_valid_sof", {tx_valid, tx_sof}, 2'b10);
                end
            end
            tx_ready = 1'b1;
            @(negedge clk);
            tx_ready = 1'b0;
        end
        chk("tx_valid_after_send", tx_valid, 1'b0);
        chk("rx_ready_in_recv", rx_ready, 1'b1);
    endtask

    task automatic recv_beats(input int n, input bit gap);
        for (int j = 0; j < n; j++) begin
            if (gap) begin
                rx_valid = 1'b0;
                @(negedge clk);
            end
            rx_valid = 1'b1;
            rx_data  = {32'(2*j+1), 32'(2*j+2)};
            chk($sformatf("rx_ready_b%0d", j), rx_ready, 1'b1);
            chk("no_early_done", {done, error}, 2'b00);
            @(negedge clk);
        end
        rx_valid = 1'b0;
    endtask

    initial begin
        errs     = 0;
        checks   = 0;
        reset    = 1'b1;
        start    = 1'b0;
        a_mat    = '0;
        b_mat    = '0;
        tx_ready = 1'b0;
        rx_data  = '0;
        rx_valid = 1'b0;

        mat_i   = 128'h01000000_00010000_00000100_00000001;
        mat_seq = 128'h01020304_05060708_090A0B0C_0D0E0F10;
        id_b[0]  = 64'h01000000_0105090D;
        id_b[1]  = 64'h00010000_02060A0E;
        id_b[2]  = 64'h00000100_03070B0F;
        id_b[3]  = 64'h00000001_04080C10;
        alt_b[0] = 64'h01020304_01000000;
        alt_b[1] = 64'h05060708_00010000;
        alt_b[2] = 64'h090A0B0C_00000100;
        alt_b[3] = 64'h0D0E0F10_00000001;
        exp_res = '0;
        for (int e = 0; e < 16; e++) exp_res[511-32*e -: 32] = 32'(e + 1);

        repeat (2) @(negedge clk);
        chk("rst_status", {busy, tx_valid, tx_sof, rx_ready, done, error}, 6'b0);
        chk("rst_result", result, '0);
        chk("rst_tx_data", tx_data, '0);
        reset = 1'b0;
        @(negedge clk);

        // identity job
        for (int k = 0; k < 4; k++) exp_b[k] = id_b[k];
        start_job(mat_i, mat_seq);
        chk("busy_after_start", busy, 1'b1);
        send_job(-1, 0);
        recv_beats(8, 1'b0);
        chk("id_done", {done, busy}, 2'b10);
        chk("id_result", result, exp_res);
        @(negedge clk);
        chk("id_done_pulse", done, 1'b0);
        chk("id_result_held", result, exp_res);

        // tx backpressure on beat 2, rx gaps
        start_job(mat_i, mat_seq);
        send_job(2, 5);
        recv_beats(8, 1'b1);
        chk("gap_done", {done, busy}, 2'b10);
        chk("gap_result", result, exp_res);
        @(negedge clk);
        chk("gap_done_pulse", done, 1'b0);

        // timeout in RECV
        start_job(mat_i, mat_seq);
        send_job(-1, 0);
        repeat (15) @(negedge clk);
        chk("to_not_yet", {error, rx_ready}, 2'b01);
        @(negedge clk);
        chk("to_error", {error, busy, rx_ready, done}, 4'b1000);
        chk("to_result_cleared", result, '0);
        @(negedge clk);
        chk("to_error_pulse", error, 1'b0);

        // next start accepted, start while busy ignored, early rx_valid faults
        start_job(mat_i, mat_seq);
        chk("restart_busy", {busy, tx_valid, tx_sof}, 3'b111);
        tx_ready = 1'b1;
        @(negedge clk);
        tx_ready = 1'b0;
        a_mat = mat_seq;
        b_mat = mat_i;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ign_start_data", tx_data, id_b[1]);
        chk("ign_start_flags", {busy, tx_valid, tx_sof}, 3'b110);
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
        chk("fault_error", {error, tx_valid, rx_ready, busy}, 4'b1000);
        @(negedge clk);
        chk("fault_idle", {error, busy, tx_valid, done}, 4'b0000);

        // reset mid-RECV after 3 beats
        for (int k = 0; k < 4; k++) exp_b[k] = alt_b[k];
        start_job(mat_seq, mat_i);
        send_job(-1, 0);
        recv_beats(3, 1'b0);
        chk("partial_slot0", result[511:448], 64'h00000001_00000002);
        reset = 1'b1;
        #1;
        chk("mid_rst_status", {busy, tx_valid, tx_sof, rx_ready, done, error}, 6'b0);
        chk("mid_rst_result", result, '0);
        @(negedge clk);
        chk("mid_rst_no_pulse", {done, error}, 2'b00);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", {done, error, busy}, 3'b000);

        // fresh job after reset
        start_job(mat_seq, mat_i);
        send_job(-1, 0);
        recv_beats(8, 1'b0);
        chk("fresh_done", {done, error, busy}, 3'b100);
        chk("fresh_result", result, exp_res);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
